// File: rtl/ref_clk_div.sv
// Multi-channel reference strobe generator: per-channel programmable divisor and start phase,
// glitch-free divisor updates while running, common synchronous start and locked status.
module ref_clk_div #(
  parameter int unsigned N_CH        = 2,
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned CH_W        = 1,
  parameter int unsigned DEFAULT_DIV = 2
) (
  input  logic              sys_clk_i,
  input  logic              reset_ni,
  input  logic              enable_i,
  input  logic              cfg_wr_i,
  input  logic [CH_W-1:0]   cfg_ch_i,
  input  logic [DIV_W-1:0]  cfg_div_i,
  input  logic [DIV_W-1:0]  cfg_phase_i,
  output logic              cfg_err_o,
  output logic [N_CH-1:0]   tick_o,
  output logic [N_CH-1:0]   clk_out_o,
  output logic              locked_o
);

  typedef logic [DIV_W-1:0] cnt_t;

  cnt_t            div_q    [N_CH];
  cnt_t            div_d    [N_CH];
  cnt_t            phase_q  [N_CH];
  cnt_t            phase_d  [N_CH];
  cnt_t            shadow_q [N_CH];
  cnt_t            shadow_d [N_CH];
  cnt_t            cnt_q    [N_CH];
  cnt_t            cnt_d    [N_CH];
  logic [N_CH-1:0] pending_q, pending_d;
  logic [N_CH-1:0] seen_q, seen_d;
  logic [N_CH-1:0] tick_q, tick_d;
  logic [N_CH-1:0] clk_q, clk_d;
  logic [N_CH-1:0] wr_hit, wrap;
  logic            running_q, running_d;
  logic            locked_q, locked_d;
  logic            cfg_err_q, cfg_err_d;
  logic            cfg_ok;

  // Counter value that makes the first tick land p edges after the start edge.
  function automatic cnt_t preload(cnt_t d, cnt_t p);
    return (p == '0) ? '0 : cnt_t'(d - p);
  endfunction

  assign cfg_ok = (32'(cfg_ch_i) < N_CH) && (cfg_div_i >= cnt_t'(2)) &&
                  (cfg_phase_i < cfg_div_i);

  always_comb begin
    running_d = enable_i;
    cfg_err_d = cfg_wr_i & ~cfg_ok;
    locked_d  = enable_i & running_q & (&seen_q) & ~(|pending_q);
    for (int i = 0; i < N_CH; i++) begin
      wr_hit[i]   = cfg_wr_i & cfg_ok & (cfg_ch_i == CH_W'(i));
      wrap[i]     = (cnt_q[i] == cnt_t'(div_q[i] - cnt_t'(1)));
      div_d[i]    = div_q[i];
      phase_d[i]  = wr_hit[i] ? cfg_phase_i : phase_q[i];
      shadow_d[i] = shadow_q[i];
      pending_d[i] = pending_q[i];
      seen_d[i]   = seen_q[i];
      cnt_d[i]    = cnt_q[i];
      tick_d[i]   = 1'b0;
      clk_d[i]    = 1'b0;
      if (enable_i) begin
        tick_d[i] = (cnt_q[i] == '0);
        clk_d[i]  = (cnt_q[i] < (div_q[i] >> 1));
        seen_d[i] = seen_q[i] | (cnt_q[i] == '0);
        if (wrap[i]) begin
          cnt_d[i] = '0;
          if (pending_q[i]) begin
            div_d[i]     = shadow_q[i];
            pending_d[i] = 1'b0;
          end
        end else begin
          cnt_d[i] = cnt_t'(cnt_q[i] + cnt_t'(1));
        end
        // A write landing on the wrap edge waits for the following wrap.
        if (wr_hit[i]) begin
          shadow_d[i]  = cfg_div_i;
          pending_d[i] = 1'b1;
        end
      end else begin
        seen_d[i]    = 1'b0;
        pending_d[i] = 1'b0;
        if (wr_hit[i]) begin
          div_d[i] = cfg_div_i;
        end else if (pending_q[i]) begin
          div_d[i] = shadow_q[i];
        end
        cnt_d[i] = preload(div_d[i], phase_d[i]);
      end
    end
  end

  always_ff @(posedge sys_clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      running_q <= 1'b0;
      locked_q  <= 1'b0;
      cfg_err_q <= 1'b0;
      pending_q <= '0;
      seen_q    <= '0;
      tick_q    <= '0;
      clk_q     <= '0;
      for (int i = 0; i < N_CH; i++) begin
        div_q[i]    <= cnt_t'(DEFAULT_DIV);
        phase_q[i]  <= '0;
        shadow_q[i] <= cnt_t'(DEFAULT_DIV);
        cnt_q[i]    <= '0;
      end
    end else begin
      running_q <= running_d;
      locked_q  <= locked_d;
      cfg_err_q <= cfg_err_d;
      pending_q <= pending_d;
      seen_q    <= seen_d;
      tick_q    <= tick_d;
      clk_q     <= clk_d;
      for (int i = 0; i < N_CH; i++) begin
        div_q[i]    <= div_d[i];
        phase_q[i]  <= phase_d[i];
        shadow_q[i] <= shadow_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
    end
  end

  assign cfg_err_o = cfg_err_q;
  assign tick_o    = tick_q;
  assign clk_out_o = clk_q;
  assign locked_o  = locked_q;

endmodule
